// File: rtl/clock_display_mux.sv
// Six-digit multiplexed HH:MM:SS display driver with per-frame snapshot and anode ghost-blanking.
// Optional COLON_BLINK_EN: dp on digits 2 and 4 follows a phase toggled by one_second_pulse.
module clock_display_mux #(
   parameter int REFRESH_DIV    = 100000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] seconds,
   input  logic [5:0] minutes,
   input  logic [4:0] hours,
   input  logic       one_second_pulse,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_start
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [5:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    digit_q, digit_d;
   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic [4:0]    hr_q, hr_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [5:0]    an_q, an_d;
   logic          frame_start_q, frame_start_d;
   logic          phase_q, phase_d;

   logic          wrap;
   logic [3:0]    code;
   logic [6:0]    glyph;
   logic [5:0]    an_raw;
   logic          dp_lit;

   // Code 15 marks an out-of-range field; both of its digits show a dash.
   function automatic logic [3:0] bcd_digit(input logic [5:0] v, input logic [5:0] lim,
                                            input logic tens);
      if (v > lim) return 4'hF;
      return tens ? 4'(v / 6'd10) : 4'(v % 6'd10);
   endfunction

   function automatic logic [6:0] glyph_al(input logic [3:0] c);
      case (c)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   always_comb begin
      wrap    = (cnt_q == CW'(REFRESH_DIV - 1));
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      digit_d = digit_q;
      if (wrap) digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;

      frame_start_d = wrap && (digit_q == 3'd5);
      sec_d = frame_start_d ? seconds : sec_q;
      min_d = frame_start_d ? minutes : min_q;
      hr_d  = frame_start_d ? hours   : hr_q;

      case (digit_q)
         3'd0:    code = bcd_digit(sec_q, 6'd59, 1'b0);
         3'd1:    code = bcd_digit(sec_q, 6'd59, 1'b1);
         3'd2:    code = bcd_digit(min_q, 6'd59, 1'b0);
         3'd3:    code = bcd_digit(min_q, 6'd59, 1'b1);
         3'd4:    code = bcd_digit({1'b0, hr_q}, 6'd23, 1'b0);
         default: code = bcd_digit({1'b0, hr_q}, 6'd23, 1'b1);
      endcase
      glyph = glyph_al(code);
      seg_d = (SEG_ACTIVE_LOW != 0) ? glyph : ~glyph;

      // Anodes stay off for the first BLANK_CYCLES of each slot to hide segment transitions.
      an_raw = (cnt_q >= CW'(BLANK_CYCLES)) ? (6'b000001 << digit_q) : 6'b000000;
      an_d   = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;

`ifdef COLON_BLINK_EN
      phase_d = phase_q ^ one_second_pulse;
      dp_lit  = phase_q && ((digit_q == 3'd2) || (digit_q == 3'd4));
`else
      phase_d = phase_q;
      dp_lit  = 1'b0;
`endif
      dp_d = (SEG_ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
   end

`ifndef COLON_BLINK_EN
   logic unused_pulse;
   assign unused_pulse = one_second_pulse ^ phase_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         digit_q       <= 3'd0;
         sec_q         <= 6'd0;
         min_q         <= 6'd0;
         hr_q          <= 5'd0;
         seg_q         <= SEG_OFF;
         dp_q          <= DP_OFF;
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
         phase_q       <= 1'b1;
      end else begin
         cnt_q         <= cnt_d;
         digit_q       <= digit_d;
         sec_q         <= sec_d;
         min_q         <= min_d;
         hr_q          <= hr_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
         phase_q       <= phase_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Scoreboard bench for clock_display_mux: cycle-indexed reference model feeds an expectation queue,
// a negedge monitor pops and compares every output.
module tb_clock_display_mux;
   localparam int DIV   = 4;
   localparam int BLK   = 1;
   localparam int FRAME = DIV * 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] seconds = 6'd0;
   logic [5:0] minutes = 6'd0;
   logic [4:0] hours = 5'd0;
   logic       one_second_pulse = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frame_start;

   clock_display_mux #(
      .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
      .one_second_pulse(one_second_pulse), .seg(seg), .dp(dp), .an(an),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [5:0] an;
      logic       fs;
   } exp_t;

   exp_t  exp_q[$];
   int    total = 0;
   int    bad = 0;
   string phase_name = "reset";

   logic [6:0] glyph_tab [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                                  7'b0111111};

   // Digit d shows field d/2 (sec, min, hr); odd digits are tens. 10 selects the dash glyph.
   function automatic int digit_code(int d, int s, int m, int h);
      int v, lim;
      case (d / 2)
         0:       begin v = s; lim = 59; end
         1:       begin v = m; lim = 59; end
         default: begin v = h; lim = 23; end
      endcase
      if (v > lim) return 10;
      return (d % 2 == 1) ? v / 10 : v % 10;
   endfunction

   int  m_t = 0;
   int  m_sec = 0, m_min = 0, m_hr = 0;
   bit  m_phase = 1'b1;
   bit  m_live = 1'b0;

   always @(posedge clk) begin : model
      exp_t e;
      int   cnt, digit;
      if (reset) begin
         e = '{seg: 7'h7F, dp: 1'b1, an: 6'h3F, fs: 1'b0};
         m_t = 0; m_sec = 0; m_min = 0; m_hr = 0; m_phase = 1'b1; m_live = 1'b1;
         exp_q.push_back(e);
      end else if (m_live) begin
         cnt   = m_t % DIV;
         digit = (m_t / DIV) % 6;
         e.seg = glyph_tab[digit_code(digit, m_sec, m_min, m_hr)];
         e.an  = (cnt >= BLK) ? ~(6'b000001 << digit) : 6'h3F;
         e.dp  = 1'b1;
`ifdef COLON_BLINK_EN
         if (m_phase && (digit == 2 || digit == 4)) e.dp = 1'b0;
         if (one_second_pulse) m_phase = !m_phase;
`endif
         e.fs = (m_t % FRAME) == FRAME - 1;
         if (e.fs) begin
            m_sec = int'(seconds); m_min = int'(minutes); m_hr = int'(hours);
         end
         m_t++;
         exp_q.push_back(e);
      end
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s [%s] t=%0t got=%b want=%b", name, phase_name, $time, got, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("seg", 32'(seg), 32'(e.seg));
         check("an", 32'(an), 32'(e.an));
         check("dp", 32'(dp), 32'(e.dp));
         check("frame_start", 32'(frame_start), 32'(e.fs));
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_time(int h, int m, int s);
      hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
   endtask

   task automatic pulse;
      one_second_pulse = 1'b1;
      step(1);
      one_second_pulse = 1'b0;
   endtask

   initial begin
      set_time(23, 59, 58);
      step(3);
      reset = 1'b0;

      phase_name = "two_frames";
      step(2 * FRAME);

      phase_name = "no_tearing";
      set_time(12, 34, 56);
      step(FRAME);
      step(10);
      set_time(1, 2, 3);
      step(3 * FRAME);

      phase_name = "out_of_range";
      set_time(24, 7, 60);
      step(3 * FRAME);

      phase_name = "reset_mid_frame";
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(3 * DIV + 2);
      reset = 1'b1;
      set_time(11, 22, 33);
      step(1);
      reset = 1'b0;
      step(2 * FRAME);

      phase_name = "blink";
      pulse();
      step(FRAME);
      pulse();
      step(FRAME);

      phase_name = "random";
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0)
            set_time(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23),
                     $urandom_range(0, 63), $urandom_range(0, 63));
         one_second_pulse = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 149) == 0);
         step(1);
      end
      one_second_pulse = 1'b0;
      reset = 1'b0;
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout [%s] got=running want=finished", phase_name);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
